// File: rtl/rv32i_types.sv
// Shared constants for the pipeline control slice: stall source indices,
// default geometry and the control-mode encoding used by pipe_ctrl_unit.
package rv32i_types;

    localparam int STALL_IMEM          = 0;
    localparam int STALL_DMEM          = 1;

    localparam int DEF_NUM_STAGES      = 4;
    localparam int DEF_NUM_STALL_SRC   = 2;
    localparam int DEF_REDIRECT_STAGE  = 1;
    localparam int DEF_HAZARD_STAGE    = 0;
    localparam int DEF_ORDER_WIDTH     = 64;
    localparam int PERF_CNT_W          = 32;

    typedef enum logic [1:0] {
        CTRL_ADVANCE,
        CTRL_HAZARD,
        CTRL_FROZEN,
        CTRL_REDIRECT
    } ctrl_mode_e;

    // Redirect beats freeze beats load-use hazard beats plain advance.
    function automatic ctrl_mode_e ctrl_mode(input logic redir, input logic frozen,
                                             input logic hazard);
        if (redir)       return CTRL_REDIRECT;
        else if (frozen) return CTRL_FROZEN;
        else if (hazard) return CTRL_HAZARD;
        else             return CTRL_ADVANCE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// Handshake bundle between the pipeline datapath and its control unit.
interface pipe_ctrl_unit_if
    import rv32i_types::*;
#(
    parameter int NUM_STAGES    = DEF_NUM_STAGES,
    parameter int NUM_STALL_SRC = DEF_NUM_STALL_SRC,
    parameter int ORDER_WIDTH   = DEF_ORDER_WIDTH
);
    logic                     fetch_valid;
    logic [NUM_STALL_SRC-1:0] stall_req;
    logic                     redirect;
    logic                     load_use;
    logic                     perf_clr;

    logic [NUM_STAGES-1:0]    stage_en;
    logic [NUM_STAGES-1:0]    stage_flush;
    logic [NUM_STAGES-1:0]    stage_valid;
    logic                     fetch_ready;
    logic                     retire_valid;
    logic [ORDER_WIDTH-1:0]   retire_order;
    logic [PERF_CNT_W-1:0]    stall_cycles;
    logic [PERF_CNT_W-1:0]    redirect_count;

    modport slave (
        input  fetch_valid, stall_req, redirect, load_use, perf_clr,
        output stage_en, stage_flush, stage_valid, fetch_ready,
               retire_valid, retire_order, stall_cycles, redirect_count
    );

    modport master (
        output fetch_valid, stall_req, redirect, load_use, perf_clr,
        input  stage_en, stage_flush, stage_valid, fetch_ready,
               retire_valid, retire_order, stall_cycles, redirect_count
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear wins over increment.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o
);
    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != '1))
            cnt_d = cnt_q + WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// In-order pipeline controller: per-stage enable/flush, valid tracking,
// retire order tagging and freeze/redirect performance counters.
module pipe_ctrl_unit
    import rv32i_types::*;
#(
    parameter int NUM_STAGES     = DEF_NUM_STAGES,
    parameter int NUM_STALL_SRC  = DEF_NUM_STALL_SRC,
    parameter int REDIRECT_STAGE = DEF_REDIRECT_STAGE,
    parameter int HAZARD_STAGE   = DEF_HAZARD_STAGE,
    parameter int ORDER_WIDTH    = DEF_ORDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_ctrl_unit_if.slave  bus
);
    localparam int LAST = NUM_STAGES - 1;

    if ((NUM_STAGES < 3) || (NUM_STAGES > 8)) begin : g_bad_num_stages
        $error("pipe_ctrl_unit: NUM_STAGES must be within 3..8");
    end
    if (!((HAZARD_STAGE < REDIRECT_STAGE) && (REDIRECT_STAGE < NUM_STAGES - 1))) begin : g_bad_stage_map
        $error("pipe_ctrl_unit: need HAZARD_STAGE < REDIRECT_STAGE < NUM_STAGES-1");
    end
    if (NUM_STALL_SRC < 1) begin : g_bad_stall_src
        $error("pipe_ctrl_unit: NUM_STALL_SRC must be at least 1");
    end

    logic [NUM_STAGES-1:0]  valid_q, valid_d;
    logic [NUM_STAGES-1:0]  en, flush, shift_in;
    logic                   frozen, redir, hazard, fetch_rdy, retire;
    logic [ORDER_WIDTH-1:0] order_q, order_d;
    ctrl_mode_e             mode;

    assign frozen = |bus.stall_req;
    assign redir  = bus.redirect & valid_q[REDIRECT_STAGE];
    assign hazard = bus.load_use & valid_q[HAZARD_STAGE] & ~redir;
    assign mode   = ctrl_mode(redir, frozen, hazard);

    always_comb begin
        en        = '1;
        flush     = '0;
        fetch_rdy = 1'b0;
        if (!rst_n) begin
            en    = '0;
            flush = '1;
        end else begin
            case (mode)
                CTRL_REDIRECT: begin
                    // Younger side is squashed even while frozen so the redirect PC can load.
                    fetch_rdy = 1'b1;
                    for (int i = 0; i < NUM_STAGES; i++) begin
                        if (i <= REDIRECT_STAGE) begin
                            en[i]    = 1'b0;
                            flush[i] = 1'b1;
                        end else begin
                            en[i]    = ~frozen;
                        end
                    end
                end
                CTRL_FROZEN: en = '0;
                CTRL_HAZARD: begin
                    for (int i = 0; i < NUM_STAGES; i++) begin
                        if (i <= HAZARD_STAGE) begin
                            en[i] = 1'b0;
                        end else if (i == HAZARD_STAGE + 1) begin
                            en[i]    = 1'b0;
                            flush[i] = 1'b1;
                        end
                    end
                end
                default: fetch_rdy = 1'b1;
            endcase
        end
    end

    assign retire   = rst_n & valid_q[LAST] & ~frozen;
    assign shift_in = {valid_q[NUM_STAGES-2:0], bus.fetch_valid};

    always_comb begin
        valid_d = ((valid_q & ~en) | (shift_in & en)) & ~flush;
        order_d = order_q + ORDER_WIDTH'(retire);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            order_q <= '0;
        end else begin
            valid_q <= valid_d;
            order_q <= order_d;
        end
    end

    sat_counter #(.WIDTH(PERF_CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (frozen),
        .clr_i (bus.perf_clr),
        .cnt_o (bus.stall_cycles)
    );

    sat_counter #(.WIDTH(PERF_CNT_W)) u_redir_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (redir & ~frozen),
        .clr_i (bus.perf_clr),
        .cnt_o (bus.redirect_count)
    );

    assign bus.stage_en     = en;
    assign bus.stage_flush  = flush;
    assign bus.stage_valid  = valid_q;
    assign bus.fetch_ready  = fetch_rdy;
    assign bus.retire_valid = retire;
    assign bus.retire_order = order_q;

endmodule

// File: doc/pipe_ctrl_unit.md
PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 Parameter NUM_STAGES, default 4: count of pipeline registers; index 0 is youngest (IF/ID), index NUM_STAGES-1 is retire (MEM/WB); legal range 3..8.
REQ-002 Parameter NUM_STALL_SRC, default 2: number of freeze requesters; bit 0 is imem, bit 1 is dmem.
REQ-003 Parameter REDIRECT_STAGE, default 1: register whose contents resolve branches.
REQ-004 Parameter HAZARD_STAGE, default 0: register holding the load-use consumer; elaboration SHALL fail unless HAZARD_STAGE < REDIRECT_STAGE < NUM_STAGES-1.
REQ-005 Parameter ORDER_WIDTH, default 64: retire order counter width.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 fetch_valid  in  1  IF stage presents a valid instruction.
REQ-009 stall_req  in  NUM_STALL_SRC  any bit high freezes the whole pipe.
REQ-010 redirect  in  1  mispredict resolved in REDIRECT_STAGE.
REQ-011 load_use  in  1  consumer in HAZARD_STAGE depends on load in HAZARD_STAGE+1.
REQ-012 perf_clr  in  1  synchronous clear of both performance counters.
REQ-013 stage_en  out  NUM_STAGES  register i loads its next-stage value this edge.
REQ-014 stage_flush  out  NUM_STAGES  register i loads all-zero (bubble) this edge.
REQ-015 stage_valid  out  NUM_STAGES  registered valid bit per stage.
REQ-016 fetch_ready  out  1  IF may advance PC this cycle.
REQ-017 retire_valid  out  1  instruction in retire stage commits this cycle.
REQ-018 retire_order  out  ORDER_WIDTH  order tag of committing instruction.
REQ-019 stall_cycles  out  32  saturating count of frozen cycles.
REQ-020 redirect_count  out  32  saturating count of accepted redirects.

Function
REQ-021 frozen = OR of stall_req; redir = redirect AND stage_valid[REDIRECT_STAGE]; hazard = load_use AND stage_valid[HAZARD_STAGE] AND NOT redir.
REQ-022 Priority: redirect over freeze over hazard over normal advance.
REQ-023 redir (frozen or not): stage_flush[0..REDIRECT_STAGE]=1, valid cleared; stages above REDIRECT_STAGE advance if not frozen, else hold.
REQ-024 Frozen, no redir: all stage_en=0, all stage_flush=0, valids hold.
REQ-025 hazard, not frozen: stage_en[0..HAZARD_STAGE]=0 (hold); stage_flush[HAZARD_STAGE+1]=1; stages above advance.
REQ-026 Normal: stage_en all 1; stage_valid[0] <= fetch_valid; stage_valid[i] <= stage_valid[i-1].
REQ-027 stage_en[i] and stage_flush[i] SHALL never both be 1.
REQ-028 fetch_ready = NOT frozen AND NOT hazard; redir forces fetch_ready=1 (redirect PC loads).
REQ-029 stage_en, stage_flush, fetch_ready, retire_valid combinational from state and inputs, zero-cycle latency.
REQ-030 retire_valid = stage_valid[NUM_STAGES-1] AND NOT frozen.
REQ-031 retire_order increments by 1 on each retire_valid cycle, wraps modulo 2^ORDER_WIDTH.
REQ-032 stall_cycles +1 per frozen cycle; redirect_count +1 per redir cycle while not frozen; both saturate at 0xFFFFFFFF.
REQ-033 perf_clr zeroes both counters next edge, overriding a same-cycle increment; retire_order unaffected.

Reset
REQ-034 rst_n low: stage_valid=0, retire_order=0, stall_cycles=0, redirect_count=0, immediately regardless of clk.
REQ-035 During reset: stage_en=0, stage_flush=all 1, retire_valid=0, fetch_ready=0.
REQ-036 Reset mid-freeze or mid-hazard discards all in-flight state; first edge after release behaves as REQ-026.

Structure
REQ-037 Shared package rv32i_types SHALL hold stall source index constants (STALL_IMEM=0, STALL_DMEM=1) and default parameter constants.
REQ-038 One sub-module, sat_counter (parametrised width, inc, clr, saturate), instantiated twice for the performance counters.

Verification
REQ-039 Reset, then fetch_valid=1 for 6 cycles -> stage_valid reaches 4'b1111 after 4 edges; retire_order 0,1,2 on successive retires.
REQ-040 stall_req=2'b10 for 3 cycles with pipe full -> stage_en=0, retire_valid=0, stall_cycles=3, order unchanged.
REQ-041 redirect with stage_valid[1]=1 -> stage_flush=4'b0011, stage_valid[1:0]=0 next edge, redirect_count=1.
REQ-042 load_use with stage_valid[0]=1 -> stage_en[0]=0, stage_flush[1]=1, fetch_ready=0 for one cycle.
REQ-043 redirect and stall_req=2'b01 same cycle -> stage_flush=4'b0011, stages 2..3 hold, redirect_count unchanged.
REQ-044 Preload stall_cycles=0xFFFFFFFE, freeze 3 cycles -> saturates 0xFFFFFFFF; perf_clr -> 0; rst_n low mid-freeze -> all valids 0 asynchronously.
